// File: rtl/mips_wb_bridge.sv
// Bridge from a simple MIPS-style CPU load/store port to a Wishbone classic master.
// One access at a time: IDLE -> BUS -> DONE -> IDLE, with misalignment checks and a bus timeout.
module mips_wb_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [1:0]  cpu_size_i,
  input  logic [31:0] cpu_wdat_i,
  output logic [31:0] cpu_rdat_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    lat_size;
  logic [1:0]    lat_off;

  logic          req_bad;
  logic [3:0]    req_sel;
  logic [31:0]   req_dat;
  logic [31:0]   rd_lane;

  // Request decode: legality, byte lanes and replicated write data.
  always_comb begin
    req_bad = 1'b0;
    req_sel = 4'b1111;
    req_dat = cpu_wdat_i;
    case (cpu_size_i)
      2'd0: begin
        req_sel = 4'b0001 << cpu_adr_i[1:0];
        req_dat = {4{cpu_wdat_i[7:0]}};
      end
      2'd1: begin
        req_bad = cpu_adr_i[0];
        req_sel = cpu_adr_i[1] ? 4'b1100 : 4'b0011;
        req_dat = {2{cpu_wdat_i[15:0]}};
      end
      2'd2: req_bad = |cpu_adr_i[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Read data: move the addressed lane down to bit 0 and zero-extend.
  always_comb begin
    rd_lane = dat_i;
    case (lat_size)
      2'd0: begin
        case (lat_off)
          2'd0:    rd_lane = {24'b0, dat_i[7:0]};
          2'd1:    rd_lane = {24'b0, dat_i[15:8]};
          2'd2:    rd_lane = {24'b0, dat_i[23:16]};
          default: rd_lane = {24'b0, dat_i[31:24]};
        endcase
      end
      2'd1:    rd_lane = lat_off[1] ? {16'b0, dat_i[31:16]} : {16'b0, dat_i[15:0]};
      default: rd_lane = dat_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_size   <= '0;
      lat_off    <= '0;
      cpu_rdat_o <= '0;
      cpu_ack_o  <= 1'b0;
      cpu_err_o  <= 1'b0;
      cpu_busy_o <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      we_o       <= 1'b0;
      sel_o      <= '0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
    end else begin
      cpu_ack_o <= 1'b0;
      cpu_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            cpu_busy_o <= 1'b1;
            state      <= DONE;
            if (req_bad) begin
              cpu_err_o <= 1'b1;
            end else begin
              adr_o    <= {cpu_adr_i[31:2], 2'b00};
              dat_o    <= req_dat;
              sel_o    <= req_sel;
              we_o     <= cpu_we_i;
              lat_size <= cpu_size_i;
              lat_off  <= cpu_adr_i[1:0];
              cyc_o    <= 1'b1;
              stb_o    <= 1'b1;
              cnt      <= '0;
              state    <= BUS;
            end
          end
        end
        BUS: begin
          // An ack in the threshold cycle still counts as a normal completion.
          if (ack_i) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            cpu_ack_o <= 1'b1;
            if (!we_o) cpu_rdat_o <= rd_lane;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            cpu_err_o  <= 1'b1;
            cpu_rdat_o <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          cpu_busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          cpu_busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_wb_bridge.sv
// Bench for mips_wb_bridge: transaction-level model predicts every cycle's outputs,
// a negedge compare process checks them, plus a few literal pinned expectations.
module tb_mips_wb_bridge;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_adr_i, cpu_wdat_i;
  logic [1:0]  cpu_size_i;
  logic [31:0] cpu_rdat_o;
  logic        cpu_ack_o, cpu_err_o, cpu_busy_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        we_o, cyc_o, stb_o, ack_i;
  logic [3:0]  sel_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          bus_cnt = 0;
  int          slave_wait = 0;
  logic        ack_force = 1'b0;

  bit          chk_en = 1'b0;
  logic        exp_cyc, exp_busy, exp_ack, exp_err, exp_we;
  logic [31:0] exp_rdat, exp_adr, exp_dat;
  logic [3:0]  exp_sel;
  logic [31:0] model_rdat = '0;

  mips_wb_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i),
    .cpu_size_i(cpu_size_i), .cpu_wdat_i(cpu_wdat_i), .cpu_rdat_o(cpu_rdat_o),
    .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o), .cpu_busy_o(cpu_busy_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave acks combinationally once stb has been up for slave_wait cycles.
  assign ack_i = ack_force | (cyc_o & stb_o & (bus_cnt == slave_wait));

  always @(posedge clk_i) begin
    if (!cyc_o) bus_cnt <= 0;
    else        bus_cnt <= bus_cnt + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check_output("cyc_o", 32'(cyc_o), 32'(exp_cyc));
      check_output("stb_o", 32'(stb_o), 32'(exp_cyc));
      check_output("cpu_busy_o", 32'(cpu_busy_o), 32'(exp_busy));
      check_output("cpu_ack_o", 32'(cpu_ack_o), 32'(exp_ack));
      check_output("cpu_err_o", 32'(cpu_err_o), 32'(exp_err));
      check_output("cpu_rdat_o", cpu_rdat_o, exp_rdat);
      if (exp_cyc) begin
        check_output("adr_o", adr_o, exp_adr);
        check_output("sel_o", 32'(sel_o), 32'(exp_sel));
        check_output("dat_o", dat_o, exp_dat);
        check_output("we_o", 32'(we_o), 32'(exp_we));
      end
    end
  end

  function automatic bit model_legal(input logic [1:0] size, input logic [31:0] a);
    int align;
    if (size == 2'd3) return 1'b0;
    align = 1 << int'(size);
    return (int'(a[1:0]) % align) == 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << int'(size);
    return 4'(((1 << nbytes) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] model_dat(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return {24'b0, w[7:0]} * 32'h01010101;
    if (size == 2'd1) return {16'b0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] model_lane(input logic [1:0] size, input logic [31:0] a,
                                             input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * int'(a[1:0]));
    if (size == 2'd0) return sh & 32'h000000FF;
    if (size == 2'd1) return sh & 32'h0000FFFF;
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_cyc  = 1'b0;
    exp_busy = 1'b0;
    exp_ack  = 1'b0;
    exp_err  = 1'b0;
    exp_rdat = model_rdat;
  endtask

  // One access, entered and left in an IDLE cycle just after a rising edge.
  task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [1:0] size,
                                input logic [31:0] wdat, input logic [31:0] rdata, input int w,
                                input bit hold, input bit pin, input logic [31:0] pin_adr,
                                input logic [3:0] pin_sel, input logic [31:0] pin_dat,
                                input logic [31:0] pin_rdat);
    int  nb;
    bit  ok;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_adr_i  = adr;
    cpu_size_i = size;
    cpu_wdat_i = wdat;
    dat_i      = rdata;
    slave_wait = w;
    next_cycle();
    if (!hold) cpu_req_i = 1'b0;
    if (!model_legal(size, adr)) begin
      exp_busy = 1'b1;
      exp_err  = 1'b1;
      next_cycle();
    end else begin
      ok = (w < TIMEOUT);
      nb = ok ? w + 1 : TIMEOUT;
      exp_cyc  = 1'b1;
      exp_busy = 1'b1;
      exp_adr  = adr & 32'hFFFF_FFFC;
      exp_sel  = model_sel(size, adr);
      exp_dat  = model_dat(size, wdat);
      exp_we   = we;
      if (pin) begin
        @(negedge clk_i);
        check_output("pin_adr_o", adr_o, pin_adr);
        check_output("pin_sel_o", 32'(sel_o), 32'(pin_sel));
        check_output("pin_dat_o", dat_o, pin_dat);
      end
      repeat (nb) next_cycle();
      exp_cyc = 1'b0;
      exp_ack = ok;
      exp_err = !ok;
      if (!ok)     model_rdat = '0;
      else if (!we) model_rdat = model_lane(size, adr, rdata);
      exp_rdat = model_rdat;
      if (pin) begin
        @(negedge clk_i);
        check_output("pin_cpu_rdat_o", cpu_rdat_o, pin_rdat);
      end
      next_cycle();
    end
    set_idle_exp();
  endtask

  initial begin
    bit          hold_prev;
    bit          hold;
    int          r;
    int          w;
    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_adr_i  = '0;
    cpu_size_i = '0;
    cpu_wdat_i = '0;
    dat_i      = '0;
    set_idle_exp();
    exp_adr = '0; exp_sel = '0; exp_dat = '0; exp_we = 1'b0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_output("rst_cyc_o", 32'(cyc_o), 32'd0);
    check_output("rst_adr_o", adr_o, 32'd0);
    check_output("rst_sel_o", 32'(sel_o), 32'd0);
    check_output("rst_busy_o", 32'(cpu_busy_o), 32'd0);
    check_output("rst_rdat_o", cpu_rdat_o, 32'd0);
    rst_i = 1'b0;
    next_cycle();
    chk_en = 1'b1;

    // Directed cases with literal expectations.
    apply_stimulus(1'b1, 32'h801, 2'd0, 32'h000000A5, 32'h0, 2, 1'b0,
                   1'b1, 32'h800, 4'b0010, 32'hA5A5A5A5, 32'h0);
    apply_stimulus(1'b0, 32'h802, 2'd1, 32'h0, 32'h12345678, 0, 1'b0,
                   1'b1, 32'h800, 4'b1100, 32'h0, 32'h00001234);
    apply_stimulus(1'b0, 32'h806, 2'd2, 32'h0, 32'h0, 0, 1'b0,
                   1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    apply_stimulus(1'b0, 32'h804, 2'd2, 32'h0, 32'hCAFEF00D, 40, 1'b0,
                   1'b1, 32'h804, 4'b1111, 32'h0, 32'h0);
    apply_stimulus(1'b0, 32'h808, 2'd2, 32'h0, 32'hDEADBEEF, TIMEOUT - 1, 1'b0,
                   1'b1, 32'h808, 4'b1111, 32'h0, 32'hDEADBEEF);
    apply_stimulus(1'b0, 32'h80B, 2'd3, 32'h0, 32'h0, 0, 1'b0,
                   1'b0, 32'h0, 4'h0, 32'h0, 32'h0);

    // Stray acks outside a bus cycle must do nothing.
    ack_force = 1'b1;
    repeat (3) next_cycle();
    ack_force = 1'b0;

    // Back-to-back with a zero-wait slave and the request held high.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'(i % 2), 32'h1000 + 32'(4 * i), 2'd2, $urandom, $urandom, 0, 1'b1,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    cpu_req_i = 1'b0;
    next_cycle();

    // Reset in the middle of a bus cycle.
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_adr_i  = 32'h900;
    cpu_size_i = 2'd2;
    dat_i      = 32'h55AA55AA;
    slave_wait = 99;
    next_cycle();
    cpu_req_i = 1'b0;
    exp_cyc = 1'b1; exp_busy = 1'b1; exp_adr = 32'h900; exp_sel = 4'hF; exp_we = 1'b0;
    repeat (3) next_cycle();
    chk_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    check_output("midrst_cyc_o", 32'(cyc_o), 32'd0);
    check_output("midrst_stb_o", 32'(stb_o), 32'd0);
    check_output("midrst_ack_o", 32'(cpu_ack_o), 32'd0);
    check_output("midrst_err_o", 32'(cpu_err_o), 32'd0);
    check_output("midrst_busy_o", 32'(cpu_busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_rdat = '0;
    set_idle_exp();
    next_cycle();
    chk_en = 1'b1;
    apply_stimulus(1'b0, 32'h800, 2'd2, 32'h0, 32'h89ABCDEF, 1, 1'b0,
                   1'b1, 32'h800, 4'b1111, 32'h0, 32'h89ABCDEF);

    // Randomized traffic.
    hold_prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!hold_prev) begin
        cpu_req_i = 1'b0;
        repeat ($urandom_range(0, 2)) next_cycle();
      end
      r = int'($urandom_range(0, 7));
      w = (r == 7) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2)) : int'($urandom_range(0, 4));
      hold = ($urandom_range(0, 2) == 0);
      apply_stimulus(1'($urandom), $urandom, 2'($urandom), $urandom, $urandom, w, hold,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
      hold_prev = hold;
    end
    cpu_req_i = 1'b0;
    repeat (3) next_cycle();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_wb_bridge.md
MIPS_WB_BRIDGE -- requirements
Module: mips_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of cycles a bus cycle may wait for ack_i before it is aborted.
REQ-002 SHALL have port clk_i  input  1: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port cpu_req_i  input  1: CPU access request, sampled only in IDLE.
REQ-005 SHALL have port cpu_we_i  input  1: 1 = write, 0 = read.
REQ-006 SHALL have port cpu_adr_i  input  32: byte address.
REQ-007 SHALL have port cpu_size_i  input  2: access size; 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 SHALL have port cpu_wdat_i  input  32: write data, right-aligned.
REQ-009 SHALL have port cpu_rdat_o  output  32: read data, right-aligned and zero-extended.
REQ-010 SHALL have port cpu_ack_o  output  1: one-cycle pulse marking successful completion.
REQ-011 SHALL have port cpu_err_o  output  1: one-cycle pulse marking a misaligned, illegal or timed-out access.
REQ-012 SHALL have port cpu_busy_o  output  1: high whenever state is not IDLE.
REQ-013 SHALL have Wishbone master ports adr_o (output 32), dat_o (output 32), dat_i (input 32), we_o (output 1), sel_o (output 4), cyc_o (output 1), stb_o (output 1) and ack_i (input 1).

Function
REQ-014 SHALL use the states IDLE, BUS and DONE, and every output SHALL be registered.
REQ-015 In IDLE with cpu_req_i=1 and a legal, aligned access, the bridge SHALL latch all CPU inputs, set cyc_o=stb_o=1 on the next edge and enter BUS.
REQ-016 SHALL treat an access as misaligned when it is a half with adr[0]=1 or a word with adr[1:0]!=0; size 3 is illegal.
REQ-017 A misaligned or illegal request SHALL start no bus cycle, SHALL pulse cpu_err_o on the next edge, and SHALL enter DONE.
REQ-018 adr_o SHALL equal {cpu_adr_i[31:2],2'b00}, and we_o SHALL equal the latched cpu_we_i.
REQ-019 sel_o SHALL be decoded from size and address:
- byte: 4'b0001 << adr[1:0]
- half: adr[1] ? 4'b1100 : 4'b0011
- word: 4'b1111
REQ-020 dat_o SHALL be driven as follows:
- byte: {4{wdat[7:0]}}
- half: {2{wdat[15:0]}}
- word: wdat
REQ-021 While cyc_o, stb_o, adr_o, dat_o, sel_o and we_o are asserted, they SHALL remain stable until ack_i or a timeout occurs.
REQ-022 In BUS, on the first edge with ack_i=1, the bridge SHALL:
- deassert cyc_o and stb_o;
- for reads, capture dat_i, shift the addressed lane down and zero-extend it into cpu_rdat_o;
- pulse cpu_ack_o;
- enter DONE.
REQ-023 For writes, cpu_rdat_o SHALL keep its previous value.
REQ-024 In BUS, a cycle counter SHALL start at 0 when BUS is entered and increment every cycle without ack_i.
REQ-025 When the counter reaches TIMEOUT-1 with ack_i=0, the bridge SHALL:
- deassert cyc_o and stb_o;
- set cpu_rdat_o to 0;
- pulse cpu_err_o;
- enter DONE.
REQ-026 If ack_i arrives in the same cycle as the timeout threshold, ack SHALL win: no error, normal completion.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE; a request present in DONE SHALL be ignored, and the CPU SHALL hold or re-assert cpu_req_i.
REQ-028 The minimum request-to-request spacing SHALL be 3 cycles for a zero-wait slave whose ack_i arrives one cycle after stb_o.
REQ-029 ack_i outside BUS SHALL be ignored.
REQ-030 cpu_ack_o and cpu_err_o SHALL never be high in the same cycle.

Reset
REQ-031 On rst_i=1, asynchronously, the block SHALL enter IDLE and clear every output and internal register: cyc_o, stb_o, we_o = 0; adr_o, dat_o, cpu_rdat_o = 0; sel_o = 0; cpu_ack_o, cpu_err_o, cpu_busy_o = 0; counter = 0.
REQ-032 Reset asserted during BUS SHALL drop cyc_o and stb_o immediately, with no ack or err pulse.
REQ-033 After reset release, the first request SHALL be accepted on the first rising edge that samples cpu_req_i=1.

Verification
REQ-034 Byte write: adr=0x801, size=0, wdat=0x000000A5, slave acks after 2 cycles -> adr_o=0x800, sel_o=0010, dat_o=0xA5A5A5A5, one cpu_ack_o pulse, cpu_err_o=0 throughout.
REQ-035 Half read: adr=0x802, size=1, slave returns dat_i=0x12345678 -> sel_o=1100, cpu_rdat_o=0x00001234, one cpu_ack_o pulse.
REQ-036 Misaligned: word access at 0x806 -> cyc_o stays 0, cpu_err_o pulses on the next edge, cpu_busy_o high for exactly 1 cycle (DONE).
REQ-037 Timeout: TIMEOUT=16, slave never acks -> cyc_o high for exactly 16 cycles, then cpu_err_o pulse and cpu_rdat_o=0; ack_i injected at counter=15 -> cpu_ack_o, no error.
REQ-038 Reset mid-BUS: rst_i asserted 3 cycles into a read -> cyc_o=0 asynchronously, no ack or err pulse; a word read of 0x800 after release completes normally.
REQ-039 Back-to-back: cpu_req_i held high with a zero-wait slave -> a new bus cycle starts every 3 cycles, and cyc_o is never high during DONE.
